// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg: shared constants and types for the FIFO word packer.
// Lane counts run 0..PACK_RATIO inclusive, hence the extra bit.
package fifo_pack_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK_RATIO = 4;
  localparam int LANE_CNT_W     = $clog2(DEF_PACK_RATIO) + 1;

  typedef logic [LANE_CNT_W-1:0] lane_cnt_t;

endpackage

// File: rtl/pack_out_stage.sv
// pack_out_stage: registered valid/ready master output.
// A word is held stable until the sink accepts it.
module pack_out_stage #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [KW-1:0] keep_i,
  output logic          free_o,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_data_o,
  output logic [KW-1:0] m_keep_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [KW-1:0] keep_q;

  assign free_o    = !valid_q || m_ready_i;
  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_keep_o  = keep_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      keep_q  <= keep_i;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: packs PACK_RATIO FIFO entries into one wide word.
// Optional partial-word flush on idle: define FIFO_PACK_FLUSH_TIMEOUT_EN.
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int PACK_RATIO     = DEF_PACK_RATIO,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep
);

  localparam int CW = $clog2(PACK_RATIO) + 1;
  localparam logic [CW-1:0] FULL = CW'(PACK_RATIO);
  localparam logic [CW-1:0] LAST = CW'(PACK_RATIO - 1);

  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] coll_q, coll_d, word;
  logic [PACK_RATIO-1:0] keep;
  logic [CW-1:0] cnt_q, cnt_d, base, room;
  logic inflight_q;
  logic free, full, done, xfer, flush, load, cap;

  assign full = (cnt_q == FULL);
  // The last lane can bypass the collect register straight to the output.
  assign done = inflight_q && (cnt_q == LAST);
  assign xfer = free && (full || done);
  assign load = xfer || flush;
  assign cap  = inflight_q && !(done && xfer);
  assign base = load ? '0 : cnt_q;
  assign room = load ? '0 : cnt_q + CW'(inflight_q);

  assign fifo_rd_en = !rst && !fifo_empty && (room < FULL);

  always_comb begin
    coll_d = coll_q;
    cnt_d  = base;
    word   = coll_q;
    keep   = '1;
    if (done) word[PACK_RATIO-1] = fifo_rd_data;
    if (cap) begin
      coll_d[base[CW-2:0]] = fifo_rd_data;
      cnt_d = base + CW'(1);
    end
`ifdef FIFO_PACK_FLUSH_TIMEOUT_EN
    if (flush) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        if (CW'(i) >= cnt_q) begin
          word[i] = '0;
          keep[i] = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      coll_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= fifo_rd_en;
      coll_q     <= coll_d;
    end
  end

`ifdef FIFO_PACK_FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q;
  logic idle;

  assign idle  = (cnt_q != '0) && !full && !inflight_q
              && fifo_empty && free;
  assign flush = idle && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= (idle && !flush) ? tmo_q + TW'(1) : '0;
  end
`else
  logic unused_tmo;

  assign flush      = 1'b0;
  assign unused_tmo = |32'(TIMEOUT_CYCLES);
`endif

  pack_out_stage #(
    .DW(DATA_WIDTH * PACK_RATIO),
    .KW(PACK_RATIO)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .data_i   (word),
    .keep_i   (keep),
    .free_o   (free),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .m_data_o (m_data),
    .m_keep_o (m_keep)
  );

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: directed and random checks of the word packer.
// Reference: bytes grouped four at a time, lane 0 first.
module tb_fifo_word_packer;

  localparam int PR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  always #5 clk = ~clk;

  fifo_word_packer dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_keep      (m_keep)
  );

  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr % 1024];
      rd_ptr <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] pend[$];
  word_t      mw;
  int errs   = 0;
  int checks = 0;
  int acc    = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [7:0] b);
    word_t w;
    mem[wr_ptr % 1024] = b;
    wr_ptr++;
    pend.push_back(b);
    if (pend.size() == PR) begin
      w.d = {pend[3], pend[2], pend[1], pend[0]};
      w.k = 4'hF;
      exp_q.push_back(w);
      pend.delete();
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  logic hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [3:0]  hold_k;

  always @(negedge clk) begin
    #3;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (fifo_rd_en) chk("rd_nonempty", fifo_empty, 0);
      if (hold_v) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hold_d);
        chk("hold_keep", m_keep, hold_k);
      end
      if (m_valid && m_ready) begin
        chk("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mw = exp_q.pop_front();
          chk("word_data", m_data, mw.d);
          chk("word_keep", m_keep, mw.k);
        end
        acc++;
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_k = m_keep;
    end
  end

  logic        rd_s [0:127];
  logic        v_s  [0:127];
  logic [31:0] d_s  [0:127];
  logic [3:0]  k_s  [0:127];

  task automatic record(int n);
    for (int i = 0; i < n; i++) begin
      #1;
      rd_s[i] = fifo_rd_en;
      v_s[i]  = m_valid;
      d_s[i]  = m_data;
      k_s[i]  = m_keep;
      step();
    end
  endtask

  task automatic scan(int n, output int nrd, output int frd,
                      output int lrd, output int nv, output int fv);
    nrd = 0; frd = 0; lrd = 0; nv = 0; fv = 0;
    for (int i = 0; i < n; i++) begin
      if (rd_s[i]) begin
        if (nrd == 0) frd = i;
        lrd = i;
        nrd++;
      end
      if (v_s[i]) begin
        if (nv == 0) fv = i;
        nv++;
      end
    end
  endtask

  task automatic wait_acc(string tag, int n);
    for (int i = 0; i < 300 && acc < n; i++) step();
    chk(tag, acc, n);
  endtask

  initial begin
    int nrd, frd, lrd, nv, fv, bad, base, tgt;
    word_t w;

    repeat (2) step();
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_keep", m_keep, 0);
    chk("rst_rd_en_empty", fifo_rd_en, 0);

    // single word, sink always ready
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    chk("rst_rd_en_full", fifo_rd_en, 0);
    step();
    rst = 1'b0;
    m_ready = 1'b1;
    record(12);
    scan(12, nrd, frd, lrd, nv, fv);
    chk("t1_reads", nrd, 4);
    chk("t1_consec", lrd - frd + 1, 4);
    chk("t1_nvalid", nv, 1);
    chk("t1_latency", fv - frd, 5);
    chk("t1_data", d_s[fv], 32'h44332211);
    chk("t1_keep", k_s[fv], 4'hF);
    wait_acc("t1_acc", 1);

    // back-pressure: output and collect register both fill up
    m_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push(8'(i));
    record(14);
    scan(14, nrd, frd, lrd, nv, fv);
    chk("t2_reads", nrd, 8);
    chk("t2_valid", v_s[13], 1);
    chk("t2_data", d_s[13], 32'h04030201);
    m_ready = 1'b1;
    wait_acc("t2_acc", 4);

    // continuous stream
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    record(24);
    scan(24, nrd, frd, lrd, nv, fv);
    chk("t3_reads", nrd, 16);
    chk("t3_consec", lrd - frd + 1, 16);
    chk("t3_nvalid", nv, 4);
    chk("t3_latency", fv - frd, 5);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      if (v_s[i] !== (i >= fv && i <= fv + 12 && (i - fv) % 4 == 0))
        bad++;
    end
    chk("t3_valid_pattern", bad, 0);
    wait_acc("t3_acc", 8);

    // reset with two lanes collected and one read in flight
    base = rd_ptr;
    push(8'hC1); push(8'hC2); push(8'hC3);
    for (int i = 0; i < 20 && rd_ptr < base + 3; i++) step();
    chk("t4_reads", rd_ptr, base + 3);
    rst = 1'b1;
    pend.delete();
    exp_q.delete();
    #1;
    chk("t4_valid", m_valid, 0);
    chk("t4_data", m_data, 0);
    chk("t4_keep", m_keep, 0);
    chk("t4_rd_en", fifo_rd_en, 0);
    step(); step();
    rst = 1'b0;
    push(8'h5A); push(8'h5B); push(8'h5C); push(8'h5D);
    wait_acc("t4_acc", 9);

    // three entries then an idle FIFO
    push(8'hA1); push(8'hA2); push(8'hA3);
`ifdef FIFO_PACK_FLUSH_TIMEOUT_EN
    pend.delete();
    w.d = 32'h00A3A2A1;
    w.k = 4'h7;
    exp_q.push_back(w);
    record(40);
    scan(40, nrd, frd, lrd, nv, fv);
    chk("t5_nvalid", nv, 1);
    chk("t5_flush_time", fv, 20);
    chk("t5_data", d_s[fv], 32'h00A3A2A1);
    chk("t5_keep", k_s[fv], 4'h7);
    wait_acc("t5_acc", 10);
`else
    record(100);
    scan(100, nrd, frd, lrd, nv, fv);
    chk("t5_nvalid", nv, 0);
    push(8'hA4);
    wait_acc("t5_acc", 10);
`endif

    // random traffic and random sink stalls
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      m_ready = ($urandom_range(3) != 0);
      if ($urandom_range(2) != 0 || bad >= 3) begin
        push(8'($urandom));
        bad = 0;
      end else begin
        bad++;
      end
      step();
    end
    m_ready = 1'b1;
    while (pend.size() != 0) push(8'($urandom));
    tgt = acc + exp_q.size();
    wait_acc("t6_acc", tgt);
    chk("t6_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
